data_mem_unit: RTL and testbench

Multi-cycle data-memory responder that consumes the M_READ/M_WRITE strobes and OPCODE produced by the instruction decoder and executes the load/store they request. It holds a word-organised data array, performs word, half-word and byte stores and word loads, and drives STALL back to the pipeline until each access completes. It sits in the MEM stage, between the decoder's memory-control outputs and the register write-back path.

---
 rtl/data_mem_unit.sv | 166 ++++++++++++++++
 tb/tb_data_mem_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/data_mem_unit.sv
// Multi-cycle MEM-stage data memory: word/half/byte stores and word loads with
// a programmable wait latency, alignment and request-conflict reporting.
module data_mem_unit #(
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 2
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        M_READ,
   input  logic        M_WRITE,
   input  logic [5:0]  OPCODE,
   input  logic [31:0] ADDR,
   input  logic [31:0] WDATA,
   output logic [31:0] RDATA,
   output logic        STALL,
   output logic        DONE,
   output logic        MISALIGN,
   output logic        REQ_ERR
);

   localparam logic [5:0] OP_SB = 6'b101000;
   localparam logic [5:0] OP_SH = 6'b101001;
   localparam logic [3:0] LAT_C = 4'(LATENCY);
   localparam int         DEPTH = 1 << ADDR_W;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_FIN  = 2'd2
   } state_t;

   state_t              state_r;
   state_t              state_nxt_s;
   logic [3:0]          cnt_r;
   logic [3:0]          cnt_nxt_s;
   logic [ADDR_W+1:0]   addr_r;
   logic [31:0]         wdata_r;
   logic [5:0]          op_r;
   logic                is_wr_r;
   logic                both_r;
   logic [31:0]         rdata_r;
   logic                done_r;
   logic                misalign_r;
   logic                req_err_r;
   logic [31:0]         mem_r [DEPTH];

   logic                req_s;
   logic                access_s;
   logic                mis_s;
   logic [3:0]          wmask_s;
   logic [31:0]         wword_s;
   logic                stall_s;
   logic                unused_s;

   // Byte stores may land anywhere; halves need even addresses; everything else needs word alignment.
   function automatic logic is_misaligned(input logic is_wr, input logic [5:0] op,
                                          input logic [1:0] lo);
      if (is_wr && (op == OP_SB)) begin
         return 1'b0;
      end else if (is_wr && (op == OP_SH)) begin
         return lo[0];
      end else begin
         return (lo != 2'b00);
      end
   endfunction

   function automatic logic [3:0] lane_mask(input logic [5:0] op, input logic [1:0] lo);
      case (op)
         OP_SB:   return 4'b0001 << lo;
         OP_SH:   return lo[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   assign unused_s = ^ADDR[31:ADDR_W+2];

   // Next-state, counter and store-lane decode.
   always_comb begin
      req_s       = M_READ | M_WRITE;
      access_s    = (state_r == ST_BUSY) && (cnt_r == 4'd1);
      mis_s       = is_misaligned(is_wr_r, op_r, addr_r[1:0]);
      wmask_s     = lane_mask(op_r, addr_r[1:0]);
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      case (op_r)
         OP_SB:   wword_s = {4{wdata_r[7:0]}};
         OP_SH:   wword_s = {2{wdata_r[15:0]}};
         default: wword_s = wdata_r;
      endcase
      case (state_r)
         ST_IDLE: begin
            if (req_s) begin
               state_nxt_s = ST_BUSY;
               cnt_nxt_s   = LAT_C;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_BUSY: begin
            cnt_nxt_s = cnt_r - 4'd1;
            if (cnt_r == 4'd1) begin
               state_nxt_s = ST_FIN;
            end else begin
               state_nxt_s = ST_BUSY;
            end
         end
         ST_FIN:  state_nxt_s = ST_IDLE;
         default: begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = 4'd0;
         end
      endcase
      stall_s = RST_N && (((state_r == ST_IDLE) && req_s) || (state_r == ST_BUSY));
   end

   // State, request capture and registered result outputs.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_r    <= ST_IDLE;
         cnt_r      <= 4'd0;
         addr_r     <= '0;
         wdata_r    <= 32'd0;
         op_r       <= 6'd0;
         is_wr_r    <= 1'b0;
         both_r     <= 1'b0;
         rdata_r    <= 32'd0;
         done_r     <= 1'b0;
         misalign_r <= 1'b0;
         req_err_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         if ((state_r == ST_IDLE) && req_s) begin
            addr_r  <= ADDR[ADDR_W+1:0];
            wdata_r <= WDATA;
            op_r    <= OPCODE;
            is_wr_r <= M_WRITE;
            both_r  <= M_READ & M_WRITE;
         end
         done_r     <= access_s;
         misalign_r <= access_s & mis_s;
         req_err_r  <= access_s & both_r;
         if (access_s && !is_wr_r && !mis_s) begin
            rdata_r <= mem_r[addr_r[ADDR_W+1:2]];
         end
      end
   end

   // Data array; contents survive reset, but a reset edge suppresses the pending store.
   always_ff @(posedge CLK) begin
      if (RST_N && access_s && is_wr_r && !mis_s) begin
         for (int i = 0; i < 4; i++) begin
            if (wmask_s[i]) begin
               mem_r[addr_r[ADDR_W+1:2]][8*i +: 8] <= wword_s[8*i +: 8];
            end
         end
      end
   end

   assign RDATA    = rdata_r;
   assign STALL    = stall_s;
   assign DONE     = done_r;
   assign MISALIGN = misalign_r;
   assign REQ_ERR  = req_err_r;

endmodule

// File: tb/tb_data_mem_unit.sv
// Randomized self-checking bench for data_mem_unit against a byte-addressed
// reference memory with per-cycle STALL/DONE timing checks.
module tb_data_mem_unit;

   localparam int LAT = 2;
   localparam logic [5:0] OP_SB = 6'b101000;
   localparam logic [5:0] OP_SH = 6'b101001;
   localparam logic [5:0] OP_SW = 6'b101011;
   localparam logic [5:0] OP_LW = 6'b100011;

   logic        CLK;
   logic        RST_N;
   logic        M_READ;
   logic        M_WRITE;
   logic [5:0]  OPCODE;
   logic [31:0] ADDR;
   logic [31:0] WDATA;
   logic [31:0] RDATA;
   logic        STALL;
   logic        DONE;
   logic        MISALIGN;
   logic        REQ_ERR;

   int          n_checks;
   int          n_errors;
   logic [7:0]  mb [4096];
   logic [31:0] mdl_rdata;

   data_mem_unit #(.ADDR_W(10), .LATENCY(LAT)) dut (
      .CLK(CLK), .RST_N(RST_N), .M_READ(M_READ), .M_WRITE(M_WRITE),
      .OPCODE(OPCODE), .ADDR(ADDR), .WDATA(WDATA), .RDATA(RDATA),
      .STALL(STALL), .DONE(DONE), .MISALIGN(MISALIGN), .REQ_ERR(REQ_ERR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One complete access, entered just after a rising edge with the unit idle.
   task automatic do_req(input string tag, input logic rd, input logic wr,
                         input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd);
      int          ba;
      logic        mis;
      logic        err;
      logic [31:0] old_rd;
      logic [31:0] exp_rd;
      ba  = int'(addr % 32'd4096);
      err = rd & wr;
      if (wr && op == OP_SB) mis = 1'b0;
      else if (wr && op == OP_SH) mis = (ba % 2) != 0;
      else mis = (ba % 4) != 0;
      old_rd = mdl_rdata;
      exp_rd = old_rd;
      if (!wr && !mis) exp_rd = {mb[ba+3], mb[ba+2], mb[ba+1], mb[ba]};
      M_READ = rd; M_WRITE = wr; OPCODE = op; ADDR = addr; WDATA = wd;
      for (int c = 0; c <= LAT + 1; c++) begin
         @(negedge CLK);
         check_val($sformatf("%s stall c%0d", tag, c), {31'd0, STALL}, (c <= LAT) ? 32'd1 : 32'd0);
         check_val($sformatf("%s done c%0d", tag, c), {31'd0, DONE}, (c == LAT + 1) ? 32'd1 : 32'd0);
         check_val($sformatf("%s misalign c%0d", tag, c), {31'd0, MISALIGN},
                   (c == LAT + 1 && mis) ? 32'd1 : 32'd0);
         check_val($sformatf("%s req_err c%0d", tag, c), {31'd0, REQ_ERR},
                   (c == LAT + 1 && err) ? 32'd1 : 32'd0);
         check_val($sformatf("%s rdata c%0d", tag, c), RDATA, (c == LAT + 1) ? exp_rd : old_rd);
         @(posedge CLK); #1;
      end
      if (wr && !mis) begin
         if (op == OP_SB) begin
            mb[ba] = wd[7:0];
         end else if (op == OP_SH) begin
            mb[ba] = wd[7:0]; mb[ba+1] = wd[15:8];
         end else begin
            mb[ba] = wd[7:0]; mb[ba+1] = wd[15:8]; mb[ba+2] = wd[23:16]; mb[ba+3] = wd[31:24];
         end
      end
      mdl_rdata = exp_rd;
      M_READ = 1'b0; M_WRITE = 1'b0;
   endtask

   initial begin
      n_checks = 0; n_errors = 0; mdl_rdata = 32'd0;
      RST_N = 1'b0; M_READ = 1'b1; M_WRITE = 1'b0; OPCODE = OP_LW; ADDR = 32'd0; WDATA = 32'd0;
      for (int k = 0; k < 2; k++) begin
         @(negedge CLK);
         check_val("rst stall", {31'd0, STALL}, 32'd0);
         if (k == 1) begin
            check_val("rst rdata", RDATA, 32'd0);
            check_val("rst done", {31'd0, DONE}, 32'd0);
            check_val("rst misalign", {31'd0, MISALIGN}, 32'd0);
            check_val("rst req_err", {31'd0, REQ_ERR}, 32'd0);
         end
      end
      @(posedge CLK); #1;
      RST_N = 1'b1; M_READ = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge CLK);
         check_val("idle stall", {31'd0, STALL}, 32'd0);
         check_val("idle done", {31'd0, DONE}, 32'd0);
      end
      @(posedge CLK); #1;

      // The array is not reset, so give the exercised region known contents.
      for (int w = 0; w < 32; w++) do_req("init", 1'b0, 1'b1, OP_SW, 32'(w * 4), $urandom);

      do_req("sw10", 1'b0, 1'b1, OP_SW, 32'h10, 32'hDEADBEEF);
      do_req("lw10", 1'b1, 1'b0, OP_LW, 32'h10, 32'd0);
      check_val("word rd", RDATA, 32'hDEADBEEF);

      do_req("sw20", 1'b0, 1'b1, OP_SW, 32'h20, 32'h11223344);
      do_req("sb21", 1'b0, 1'b1, OP_SB, 32'h21, 32'h000000AA);
      do_req("sh22", 1'b0, 1'b1, OP_SH, 32'h22, 32'h00005566);
      do_req("lw20", 1'b1, 1'b0, OP_LW, 32'h20, 32'd0);
      check_val("partial rd", RDATA, 32'h5566AA44);

      do_req("sw31", 1'b0, 1'b1, OP_SW, 32'h31, 32'hCAFEF00D);
      do_req("lw30", 1'b1, 1'b0, OP_LW, 32'h30, 32'd0);
      do_req("sw1004", 1'b0, 1'b1, OP_SW, 32'h1004, 32'd7);
      do_req("lw4", 1'b1, 1'b0, OP_LW, 32'h4, 32'd0);
      check_val("wrap rd", RDATA, 32'd7);

      do_req("both40", 1'b1, 1'b1, OP_SW, 32'h40, 32'h12345678);
      check_val("both keeps rdata", RDATA, 32'd7);
      do_req("lw40", 1'b1, 1'b0, OP_LW, 32'h40, 32'd0);
      check_val("both stored", RDATA, 32'h12345678);

      // Reset during BUSY: store abandoned, no completion pulse.
      M_WRITE = 1'b1; OPCODE = OP_SW; ADDR = 32'h50; WDATA = 32'hFFFFFFFF;
      @(negedge CLK);
      check_val("rmid stall c0", {31'd0, STALL}, 32'd1);
      @(posedge CLK); #1;
      RST_N = 1'b0;
      @(negedge CLK);
      check_val("rmid stall forced", {31'd0, STALL}, 32'd0);
      check_val("rmid done", {31'd0, DONE}, 32'd0);
      @(posedge CLK); #1;
      RST_N = 1'b1; M_WRITE = 1'b0; mdl_rdata = 32'd0;
      for (int k = 0; k < 4; k++) begin
         @(negedge CLK);
         check_val("rmid post done", {31'd0, DONE}, 32'd0);
         check_val("rmid post stall", {31'd0, STALL}, 32'd0);
         check_val("rmid post rdata", RDATA, 32'd0);
         @(posedge CLK); #1;
      end
      do_req("lw50", 1'b1, 1'b0, OP_LW, 32'h50, 32'd0);

      for (int n = 0; n < 150; n++) begin
         int          kind;
         int          sel;
         logic [5:0]  op;
         logic [31:0] a;
         kind = $urandom_range(0, 9);
         sel  = $urandom_range(0, 3);
         op   = (sel == 0) ? OP_SB : (sel == 1) ? OP_SH : (sel == 2) ? OP_SW : 6'($urandom);
         a    = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) begin
            @(negedge CLK);
            check_val("gap stall", {31'd0, STALL}, 32'd0);
            @(posedge CLK); #1;
         end
         if (kind < 4) do_req("rnd ld", 1'b1, 1'b0, op, a, $urandom);
         else if (kind < 9) do_req("rnd st", 1'b0, 1'b1, op, a, $urandom);
         else do_req("rnd both", 1'b1, 1'b1, op, a, $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
